// File: rtl/ternary_fetch_unit_pkg.sv
// Shared trit encodings, default sizes and single-trit arithmetic for the ternary fetch path.
// Optional illegal-trit reporting is enabled by defining FETCH_TRIT_CHECK_EN.
package ternary_fetch_unit_pkg;

  localparam int DEFAULT_WORD_SIZE     = 9;
  localparam int DEFAULT_MEM_ADDR_SIZE = 3;

  typedef enum logic [1:0] {
    TRIT_ZERO    = 2'b00,
    TRIT_ONE     = 2'b01,
    TRIT_TWO     = 2'b10,
    TRIT_ILLEGAL = 2'b11
  } trit_e;

  // Returns {carry, trit+1}; an illegal trit is treated as zero.
  function automatic logic [2:0] trit_add_one(input logic [1:0] t);
    case (t)
      TRIT_ONE: return {1'b0, TRIT_TWO};
      TRIT_TWO: return {1'b1, TRIT_ZERO};
      default:  return {1'b0, TRIT_ONE};
    endcase
  endfunction

endpackage

// File: rtl/ternary_fetch_unit_if.sv
// Bus between the fetch unit, instruction memory and decode.
// The illegal_trit signal exists only when FETCH_TRIT_CHECK_EN is defined.
interface ternary_fetch_unit_if
  import ternary_fetch_unit_pkg::*;
#(
  parameter int WORD_SIZE     = DEFAULT_WORD_SIZE,
  parameter int MEM_ADDR_SIZE = DEFAULT_MEM_ADDR_SIZE
);
  logic                       mem_read_enable;
  logic [2*MEM_ADDR_SIZE-1:0] mem_address;
  logic [2*WORD_SIZE-1:0]     mem_data_out;
  logic                       redirect_valid;
  logic [2*MEM_ADDR_SIZE-1:0] redirect_pc;
  logic                       instr_valid;
  logic                       instr_ready;
  logic [2*WORD_SIZE-1:0]     instr;
  logic [2*MEM_ADDR_SIZE-1:0] instr_pc;
  logic                       fetch_busy;

`ifdef FETCH_TRIT_CHECK_EN
  logic                       illegal_trit;

  modport master (
    output mem_read_enable, mem_address, instr_valid, instr, instr_pc, fetch_busy, illegal_trit,
    input  mem_data_out, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_read_enable, mem_address, instr_valid, instr, instr_pc, fetch_busy, illegal_trit,
    output mem_data_out, redirect_valid, redirect_pc, instr_ready
  );
`else
  modport master (
    output mem_read_enable, mem_address, instr_valid, instr, instr_pc, fetch_busy,
    input  mem_data_out, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  mem_read_enable, mem_address, instr_valid, instr, instr_pc, fetch_busy,
    output mem_data_out, redirect_valid, redirect_pc, instr_ready
  );
`endif

endinterface

// File: rtl/ternary_fetch_unit_incrementer.sv
// Unbalanced-ternary +1 with carry ripple; all-twos wraps to zero without a flag.
// Shared by the fetch PC and the ALU/PC logic.
module ternary_incrementer
  import ternary_fetch_unit_pkg::*;
#(
  parameter int TRITS = DEFAULT_MEM_ADDR_SIZE
) (
  input  logic [2*TRITS-1:0] value,
  output logic [2*TRITS-1:0] result
);

  always_comb begin
    logic       carry;
    logic [2:0] sum;
    carry  = 1'b1;
    sum    = '0;
    result = '0;
    for (int i = 0; i < TRITS; i++) begin
      if (carry) begin
        sum                = trit_add_one(value[2*i +: 2]);
        result[2*i +: 2]   = sum[1:0];
        carry              = sum[2];
      end else begin
        // Trits above the carry are passed through, with illegal codes cleaned to zero.
        result[2*i +: 2]   = (value[2*i +: 2] == TRIT_ILLEGAL) ? TRIT_ZERO : value[2*i +: 2];
      end
    end
  end

endmodule

// File: rtl/ternary_fetch_unit.sv
// Instruction fetch: ternary PC, registered memory read strobe, prefetch FIFO and decode handshake.
// Define FETCH_TRIT_CHECK_EN to add the registered illegal_trit report on captured words.
module ternary_fetch_unit
  import ternary_fetch_unit_pkg::*;
#(
  parameter int                         WORD_SIZE     = DEFAULT_WORD_SIZE,
  parameter int                         MEM_ADDR_SIZE = DEFAULT_MEM_ADDR_SIZE,
  parameter int                         FIFO_DEPTH    = 2,
  parameter logic [2*MEM_ADDR_SIZE-1:0] RESET_PC      = '0
) (
  input logic                  clock,
  input logic                  reset,
  ternary_fetch_unit_if.master bus
);

  localparam int AW    = 2 * MEM_ADDR_SIZE;
  localparam int DW    = 2 * WORD_SIZE;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W = CNT_W + 2;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  logic [AW-1:0]    pc;
  logic [AW-1:0]    pc_inc;
  logic             vld_p0;
  logic [AW-1:0]    addr_p0;
  logic             epoch_p0;
  logic             vld_p1;
  logic [AW-1:0]    addr_p1;
  logic             epoch_p1;
  logic             epoch;

  logic [CNT_W-1:0] occ;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [DW-1:0]    fifo_data [FIFO_DEPTH];
  logic [AW-1:0]    fifo_pc   [FIFO_DEPTH];

  logic             pop;
  logic             capture;
  logic             issue;
  logic [CRD_W-1:0] credits;

  ternary_incrementer #(.TRITS(MEM_ADDR_SIZE)) u_pc_inc (
    .value  (pc),
    .result (pc_inc)
  );

  // Credits count every word that will occupy a FIFO slot once the reads already
  // issued have landed, so a new read can never find the FIFO full on capture.
  always_comb begin
    pop     = (occ != '0) && bus.instr_ready;
    capture = vld_p1 && (epoch_p1 == epoch) && !bus.redirect_valid;
    credits = CRD_W'(occ) + CRD_W'(vld_p0) + CRD_W'(capture) - CRD_W'(pop);
    issue   = !bus.redirect_valid && (credits < CRD_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      vld_p0   <= 1'b0;
      addr_p0  <= RESET_PC;
      epoch_p0 <= 1'b0;
      vld_p1   <= 1'b0;
      epoch_p1 <= 1'b0;
      epoch    <= 1'b0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      // p0 -> p1: strobe cycle becomes the memory data cycle
      vld_p1   <= vld_p0;
      epoch_p1 <= epoch_p0;
      if (bus.redirect_valid) begin
        pc     <= bus.redirect_pc;
        vld_p0 <= 1'b0;
        epoch  <= ~epoch;
        occ    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        vld_p0 <= issue;
        if (issue) begin
          addr_p0  <= pc;
          epoch_p0 <= epoch;
          pc       <= pc_inc;
        end
        if (capture) wr_ptr <= ptr_next(wr_ptr);
        if (pop)     rd_ptr <= ptr_next(rd_ptr);
        occ <= occ + CNT_W'(capture) - CNT_W'(pop);
      end
    end
  end

  // p1 -> FIFO: capture the returned word with the address it came from
  always_ff @(posedge clock) begin
    addr_p1 <= addr_p0;
    if (capture) begin
      fifo_data[wr_ptr] <= bus.mem_data_out;
      fifo_pc[wr_ptr]   <= addr_p1;
    end
  end

  assign bus.mem_read_enable = vld_p0;
  assign bus.mem_address     = addr_p0;
  assign bus.instr_valid     = (occ != '0);
  assign bus.instr           = (occ != '0) ? fifo_data[rd_ptr] : '0;
  assign bus.instr_pc        = (occ != '0) ? fifo_pc[rd_ptr] : '0;
  assign bus.fetch_busy      = vld_p0 || vld_p1 || (occ != '0);

`ifdef FETCH_TRIT_CHECK_EN
  function automatic logic has_illegal_trit(input logic [DW-1:0] w);
    for (int i = 0; i < WORD_SIZE; i++) begin
      if (w[2*i +: 2] == TRIT_ILLEGAL) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic illegal_p2;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) illegal_p2 <= 1'b0;
    else       illegal_p2 <= capture && has_illegal_trit(bus.mem_data_out);
  end

  assign bus.illegal_trit = illegal_p2;
`endif

endmodule
